// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage that owns the PC and the IF/ID register.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   freeze         hazard stall: hold PC and IF/ID
//   branch_taken   redirect request from execute (priority over freeze)
//   branch_addr    redirect target, bits [1:0] ignored
//   mem_req        fetch request (FETCH and DRAIN states)
//   mem_addr       word-aligned fetch address
//   mem_ack        memory returns mem_rdata this cycle
//   mem_rdata      fetched instruction
//   pc_out         address of delivered instruction + 4
//   instr_out      delivered instruction (BUBBLE_INSTR when not valid)
//   valid_out      instr_out/pc_out carry a real instruction
//   dbg_state      current FSM state (IDLE=0, FETCH=1, DRAIN=2, HOLD=3)
//   fetch_cnt      (IF_PERF_CNT_EN only) count of new valid instructions delivered
//   bubble_cnt     (IF_PERF_CNT_EN only) count of unfrozen cycles with valid_out=0
//
// Optional feature macro: IF_PERF_CNT_EN adds the saturating performance counters.
//
// Memory handshake: once mem_req is high, mem_addr is held stable until a cycle
// with mem_ack high; mem_rdata is sampled only in that cycle, and a new address
// may appear on the very next cycle. Dropping mem_req without an ack happens only
// on reset, and the memory must tolerate it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic [1:0]  dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        load_new;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic        unused_addr_bits;

  assign pc_plus4         = pc_q + 32'd4;
  assign branch_tgt       = {branch_addr[31:2], 2'b00};
  assign unused_addr_bits = ^branch_addr[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;
    load_new     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (branch_taken) begin
          pc_d        = branch_tgt;
          valid_d     = 1'b0;
          instr_d     = BUBBLE_INSTR;
          buf_valid_d = 1'b0;
          // An unacked request must still complete at its old address.
          if (!mem_ack) begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (freeze) begin
          if (mem_ack) begin
            buf_instr_d = mem_rdata;
            buf_pc_d    = pc_plus4;
            buf_valid_d = 1'b1;
            pc_d        = pc_plus4;
            state_d     = ST_HOLD;
          end
        end else if (mem_ack) begin
          instr_d  = mem_rdata;
          pc_out_d = pc_plus4;
          valid_d  = 1'b1;
          pc_d     = pc_plus4;
          load_new = 1'b1;
        end else begin
          valid_d = 1'b0;
          instr_d = BUBBLE_INSTR;
        end
      end
      ST_DRAIN: begin
        // IF/ID is already a bubble here; only the redirect target moves.
        if (branch_taken) pc_d = branch_tgt;
        if (mem_ack) state_d = ST_FETCH;
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_d        = branch_tgt;
          valid_d     = 1'b0;
          instr_d     = BUBBLE_INSTR;
          buf_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end else if (!freeze) begin
          instr_d     = buf_instr_q;
          pc_out_d    = buf_pc_q;
          valid_d     = buf_valid_q;
          load_new    = buf_valid_q;
          buf_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      drain_addr_q <= 32'h0;
      instr_q      <= BUBBLE_INSTR;
      pc_out_q     <= 32'h0;
      valid_q      <= 1'b0;
      buf_instr_q  <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      buf_valid_q  <= buf_valid_d;
    end
  end

  assign mem_req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign mem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign pc_out    = pc_out_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;
  assign dbg_state = state_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        bubble_cycle;

  assign bubble_cycle = (state_q != ST_IDLE) && !valid_q && !freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (load_new && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble_cycle && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit. Memory returns addr ^ 32'hA5A5_0000.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .dbg_state    (dbg_state)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        sb_en = 1'b0;
  logic        prev_v = 1'b0;
  logic [31:0] prev_i = 32'h0;

  function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] baddr,
                              input logic ack, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] ins, input logic [31:0] pco);
    vec_t v;
    v.frz = frz; v.br = br; v.baddr = baddr; v.ack = ack;
    v.exp_req = req; v.exp_addr = addr;
    v.exp_valid = vld; v.exp_instr = ins; v.exp_pc = pco;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver: apply one vector at a falling edge, check request side now and IF/ID after the edge
  task automatic apply(input int idx, input vec_t v);
    freeze       = v.frz;
    branch_taken = v.br;
    branch_addr  = v.baddr;
    mem_ack      = v.ack;
    mem_rdata    = mem_addr ^ 32'hA5A5_0000;
    check("mem_req", idx, {31'h0, mem_req}, {31'h0, v.exp_req});
    check("mem_addr", idx, mem_addr, v.exp_addr);
    @(posedge clk);
    @(negedge clk);
    check("valid_out", idx, {31'h0, valid_out}, {31'h0, v.exp_valid});
    check("instr_out", idx, instr_out, v.exp_instr);
    check("pc_out", idx, pc_out, v.exp_pc);
  endtask

  // scoreboard: every new valid instruction must match the next expected delivery
  always @(negedge clk) begin
    if (sb_en) begin
      if (valid_out && (!prev_v || instr_out != prev_i)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got %h expected none", instr_out);
        end else begin
          check("sb_deliver", 0, instr_out, exp_q.pop_front());
        end
      end
      prev_v = valid_out;
      prev_i = instr_out;
    end
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    //        frz br baddr          ack req addr           vld instr          pc_out
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 32'h0,          32'h0));        // 0 IDLE
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0000, 1, 32'hA5A5_0000, 32'h4));        // 1 ack every cycle
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'hA5A5_0004, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'hA5A5_0008, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_000C, 0, 32'h0,          32'hC));        // 4 ack every 3rd
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_000C, 0, 32'h0,          32'hC));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_000C, 1, 32'hA5A5_000C, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h0000_0010, 1, 32'hA5A5_000C, 32'h10));       // 7 freeze x4
    vecs.push_back(mk(1, 0, 32'h0,         1, 1, 32'h0000_0010, 1, 32'hA5A5_000C, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0000_0014, 1, 32'hA5A5_000C, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0000_0014, 1, 32'hA5A5_000C, 32'h10));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0000_0014, 1, 32'hA5A5_0010, 32'h14));       // 11 release
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0014, 1, 32'hA5A5_0014, 32'h18));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0018, 1, 32'hA5A5_0018, 32'h1C));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_001C, 1, 32'hA5A5_001C, 32'h20));
    vecs.push_back(mk(0, 1, 32'h0000_0103, 0, 1, 32'h0000_0020, 0, 32'h0,          32'h20));       // 15 branch, unacked
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_0020, 0, 32'h0,          32'h20));       // DRAIN
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0020, 0, 32'h0,          32'h20));       // dropped
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0100, 1, 32'hA5A5_0100, 32'h104));
    vecs.push_back(mk(1, 1, 32'h0000_0200, 1, 1, 32'h0000_0104, 0, 32'h0,          32'h104));      // 19 branch+freeze+ack
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0200, 1, 32'hA5A5_0200, 32'h204));
    vecs.push_back(mk(1, 0, 32'h0,         1, 1, 32'h0000_0204, 1, 32'hA5A5_0200, 32'h204));      // 21 into HOLD
    vecs.push_back(mk(1, 1, 32'h0000_0300, 0, 0, 32'h0000_0208, 0, 32'h0,          32'h204));      // branch from HOLD
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0300, 1, 32'hA5A5_0300, 32'h304));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 1, 1, 32'h0000_0304, 0, 32'h0,          32'h304));      // 24 branch to top
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'h5A5A_FFFC, 32'h0));        // wrap
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0000_0000, 0, 32'h0,          32'h0));        // 27 DRAIN re-branch
    vecs.push_back(mk(0, 1, 32'h0000_0080, 0, 1, 32'h0000_0000, 0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0000_0080, 1, 32'hA5A5_0080, 32'h84));

    // expected deliveries, derived from the table itself
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp_valid &&
          !(i > 0 && vecs[i-1].exp_valid && vecs[i-1].exp_instr == vecs[i].exp_instr))
        exp_q.push_back(vecs[i].exp_instr);
    end

    // reset state
    #12;
    check("rst_req", 0, {31'h0, mem_req}, 32'h0);
    check("rst_valid", 0, {31'h0, valid_out}, 32'h0);
    check("rst_instr", 0, instr_out, 32'h0);
    check("rst_pc_out", 0, pc_out, 32'h0);
    check("rst_state", 0, {30'h0, dbg_state}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", 0, fetch_cnt, 32'h0);
    check("rst_bubble_cnt", 0, bubble_cnt, 32'h0);
`endif

    @(negedge clk);
    rst = 1'b1;
    sb_en = 1'b1;
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    @(negedge clk);
    sb_en = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_missing: got %0d undelivered expected 0", exp_q.size());
    end

    // reset pulsed mid-request: outputs drop within the same cycle
    freeze = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0;
    check("pre_rst_req", 0, {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 0, {31'h0, mem_req}, 32'h0);
    check("mid_rst_valid", 0, {31'h0, valid_out}, 32'h0);
    check("mid_rst_instr", 0, instr_out, 32'h0);
    check("mid_rst_state", 0, {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_req", 0, {31'h0, mem_req}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("first_req", 0, {31'h0, mem_req}, 32'h1);
    check("first_addr", 0, mem_addr, 32'h0);
    check("first_state", 0, {30'h0, dbg_state}, 32'h1);
    mem_ack = 1'b1;
    mem_rdata = mem_addr ^ 32'hA5A5_0000;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("re_valid", 0, {31'h0, valid_out}, 32'h1);
    check("re_instr", 0, instr_out, 32'hA5A5_0000);
    check("re_pc_out", 0, pc_out, 32'h4);
`ifdef IF_PERF_CNT_EN
    check("re_fetch_cnt", 0, fetch_cnt, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode stage; owns the PC and the IF/ID pipeline register.
- Issues word fetches to instruction memory over a req/ack handshake.
- Presents instruction, PC+4 and a valid flag to decode.
- Honours freeze from the hazard unit and branch redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUBBLE_INSTR, 32'h0000_0000, value driven on instr_out when valid_out=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hazard stall; hold PC and the IF/ID register.
- branch_taken  in  1  redirect request from execute.
- branch_addr  in  32  redirect target; bits [1:0] ignored.
- mem_req  out  1  fetch request.
- mem_addr  out  32  fetch word address; bits [1:0] always 0.
- mem_ack  in  1  memory has mem_rdata valid this cycle.
- mem_rdata  in  32  fetched instruction.
- pc_out  out  32  address of delivered instruction + 4.
- instr_out  out  32  delivered instruction.
- valid_out  out  1  instr_out/pc_out hold a real instruction.

Behaviour:
- Reset values (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, mem_req=0.
  - pc_out=0, instr_out=BUBBLE_INSTR, valid_out=0, hold buffer empty.
- States: IDLE, FETCH, DRAIN, HOLD. mem_req=1 in FETCH and DRAIN, else 0. mem_addr=pc in FETCH, =latched old address in DRAIN.
- IDLE -> FETCH on the first clock after reset release. mem_req therefore first rises one cycle after rst deasserts.
- Handshake:
  - Once mem_req=1, mem_addr stays stable until a cycle with mem_ack=1.
  - mem_rdata is sampled only in that cycle.
  - Back-to-back requests are allowed: ack at cycle n, new address from cycle n+1.
- FETCH, ack=1, freeze=0: instr_out<=mem_rdata, pc_out<=pc+4, valid_out<=1, pc<=pc+4. Stay in FETCH. Fetch-to-decode latency is 1 cycle after ack.
- FETCH, ack=0, freeze=0: IF/ID loads a bubble (valid_out<=0, instr_out<=BUBBLE_INSTR, pc_out holds). PC holds.
- FETCH, freeze=1:
  - IF/ID outputs hold.
  - If ack=1: capture mem_rdata and pc+4 into the hold buffer, pc<=pc+4, go to HOLD.
  - If ack=0: keep requesting.
- HOLD, freeze=1: no request; outputs hold.
- HOLD, freeze=0: buffer -> IF/ID with valid_out<=1. Buffer cleared. Go to FETCH.
- branch_taken=1 (any state except IDLE) has priority over freeze:
  - pc<={branch_addr[31:2],2'b00}.
  - IF/ID flushed to bubble (valid_out<=0, instr_out<=BUBBLE_INSTR); hold buffer discarded.
  - From FETCH with ack=0: go to DRAIN, keeping the old address latched.
  - From FETCH with ack=1, or from HOLD: data dropped, go to FETCH.
- DRAIN:
  - mem_req stays 1 with the old address until ack; returned data is dropped.
  - On ack go to FETCH, which then requests the new pc.
  - A second branch_taken during DRAIN updates pc only.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- pc_out uses the same wrap rule.
- Reset mid-transaction:
  - All state returns to reset values immediately.
  - The outstanding request is abandoned. Memory must tolerate mem_req dropping without an ack.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each cycle in which valid_out rises or reloads with a new valid instruction.
  - bubble_cnt increments on each cycle after IDLE in which valid_out=0 and freeze=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
- Reset then memory acking every cycle with rdata=addr^32'hA5A5_0000: mem_addr walks 0,4,8,...; valid_out=1 from cycle 3 after reset release; instr_out=32'hA5A5_0000 with pc_out=4, then 32'hA5A5_0004 with pc_out=8.
- Ack only every 3rd cycle: mem_addr stable between acks; two bubble cycles (valid_out=0, instr_out=0) between valid instructions; pc_out sequence 4,8,12.
- freeze=1 for 4 cycles with ack at addr 0x10 during freeze: outputs hold; mem_req=0 after the capture; on freeze release instr_out=mem[0x10], pc_out=0x14; next request at 0x14.
- branch_taken with branch_addr=0x103 while a request to 0x20 is unacked: valid_out=0 next cycle; mem_addr stays 0x20 until ack; that data is not delivered; next mem_addr=0x100; delivered pc_out=0x104.
- branch_taken and freeze both high, same cycle as ack: branch wins; IF/ID flushed; next mem_addr=branch_addr.
- Branch to 32'hFFFF_FFFC, ack immediately: pc_out=0 and next mem_addr=0. rst pulsed low mid-request: mem_req=0, valid_out=0 within the same cycle.
